// File: rtl/axil_if.sv
// AXI4-Lite channel bundle shared by axil_master and axil_dpmem.
// The master modport drives the request channels; the slave modport answers them.
interface axil_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  AW_VALID;
  logic                  AW_READY;
  logic [ADDR_WIDTH-1:0] AW_ADDR;
  logic                  W_VALID;
  logic                  W_READY;
  logic [DATA_WIDTH-1:0] W_DATA;
  logic [STRB_WIDTH-1:0] W_STRB;
  logic                  B_VALID;
  logic                  B_READY;
  logic [1:0]            B_RESP;
  logic                  AR_VALID;
  logic                  AR_READY;
  logic [ADDR_WIDTH-1:0] AR_ADDR;
  logic                  R_VALID;
  logic                  R_READY;
  logic [DATA_WIDTH-1:0] R_DATA;
  logic [1:0]            R_RESP;

  modport master (
    output AW_VALID, AW_ADDR, W_VALID, W_DATA, W_STRB, B_READY, AR_VALID, AR_ADDR, R_READY,
    input  AW_READY, W_READY, B_VALID, B_RESP, AR_READY, R_VALID, R_DATA, R_RESP
  );

  modport slave (
    input  AW_VALID, AW_ADDR, W_VALID, W_DATA, W_STRB, B_READY, AR_VALID, AR_ADDR, R_READY,
    output AW_READY, W_READY, B_VALID, B_RESP, AR_READY, R_VALID, R_DATA, R_RESP
  );
endinterface

// File: rtl/axil_master.sv
// AXI4-Lite initiator: one outstanding command at a time, turned into AW/W/B or AR/R traffic.
// Optional watchdog enabled by defining AXIL_MST_TIMEOUT_EN.
module axil_master #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_we,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  axil_if.master                  m_axil
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("axil_master: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_RESP = 3'd4,
    S_RSP     = 3'd5
  } state_t;

  state_t                state;
  logic                  cmd_ready_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic                  aw_valid_q, w_valid_q, ar_valid_q;
  logic                  b_ready_q, r_ready_q;
  logic                  aw_done, w_done;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic [1:0]            rsp_resp_q;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign aw_hs = aw_valid_q & m_axil.AW_READY;
  assign w_hs  = w_valid_q  & m_axil.W_READY;
  assign b_hs  = b_ready_q  & m_axil.B_VALID;
  assign ar_hs = ar_valid_q & m_axil.AR_READY;
  assign r_hs  = r_ready_q  & m_axil.R_VALID;

`ifdef AXIL_MST_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] tmo_cnt;
  logic             in_wait, any_hs, tmo_hit, rsp_timeout_q;

  assign in_wait = (state == S_WR_REQ) || (state == S_WR_RESP) ||
                   (state == S_RD_REQ) || (state == S_RD_RESP);
  assign any_hs  = aw_hs | w_hs | b_hs | ar_hs | r_hs;
  assign tmo_hit = in_wait && !any_hs && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: idle outside the wait states, restarted by any forward progress.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      tmo_cnt <= '0;
    end else if (!in_wait || any_hs) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end

  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state         <= S_IDLE;
      cmd_ready_q   <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      aw_valid_q    <= 1'b0;
      w_valid_q     <= 1'b0;
      ar_valid_q    <= 1'b0;
      b_ready_q     <= 1'b0;
      r_ready_q     <= 1'b0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= 2'b00;
`ifdef AXIL_MST_TIMEOUT_EN
      rsp_timeout_q <= 1'b0;
`endif
    end else
`ifdef AXIL_MST_TIMEOUT_EN
    // Abort: release every channel and report a forced DECERR with the timeout flag.
    if (tmo_hit) begin
      aw_valid_q    <= 1'b0;
      w_valid_q     <= 1'b0;
      ar_valid_q    <= 1'b0;
      b_ready_q     <= 1'b0;
      r_ready_q     <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= 2'b11;
      rsp_timeout_q <= 1'b1;
      rsp_valid_q   <= 1'b1;
      state         <= S_RSP;
    end else
`endif
    begin
      case (state)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            addr_q      <= cmd_addr;
            wdata_q     <= cmd_wdata;
            wstrb_q     <= cmd_wstrb;
`ifdef AXIL_MST_TIMEOUT_EN
            rsp_timeout_q <= 1'b0;
`endif
            if (cmd_we) begin
              aw_valid_q <= 1'b1;
              w_valid_q  <= 1'b1;
              aw_done    <= 1'b0;
              w_done     <= 1'b0;
              state      <= S_WR_REQ;
            end else begin
              ar_valid_q <= 1'b1;
              state      <= S_RD_REQ;
            end
          end
        end

        // AW and W retire independently, in either order.
        S_WR_REQ: begin
          if (aw_hs) begin
            aw_valid_q <= 1'b0;
            aw_done    <= 1'b1;
          end
          if (w_hs) begin
            w_valid_q <= 1'b0;
            w_done    <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            b_ready_q <= 1'b1;
            state     <= S_WR_RESP;
          end
        end

        S_WR_RESP: begin
          if (b_hs) begin
            b_ready_q   <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= m_axil.B_RESP;
            rsp_valid_q <= 1'b1;
            state       <= S_RSP;
          end
        end

        S_RD_REQ: begin
          if (ar_hs) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            state      <= S_RD_RESP;
          end
        end

        S_RD_RESP: begin
          if (r_hs) begin
            r_ready_q   <= 1'b0;
            rsp_rdata_q <= m_axil.R_DATA;
            rsp_resp_q  <= m_axil.R_RESP;
            rsp_valid_q <= 1'b1;
            state       <= S_RSP;
          end
        end

        S_RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state       <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready       = cmd_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_rdata       = rsp_rdata_q;
  assign rsp_resp        = rsp_resp_q;
  assign m_axil.AW_VALID = aw_valid_q;
  assign m_axil.AW_ADDR  = addr_q;
  assign m_axil.W_VALID  = w_valid_q;
  assign m_axil.W_DATA   = wdata_q;
  assign m_axil.W_STRB   = wstrb_q;
  assign m_axil.B_READY  = b_ready_q;
  assign m_axil.AR_VALID = ar_valid_q;
  assign m_axil.AR_ADDR  = addr_q;
  assign m_axil.R_READY  = r_ready_q;

endmodule

// File: tb/tb_axil_master.sv
// Bench for axil_master: a 16-word AXI-Lite memory slave with controllable ready/latency,
// a directed vector table, multi-cycle corner sequences and a randomized run against a reference memory.
module tb_axil_master;
  localparam int unsigned TO_CYC = 16;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  sresp;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;

  axil_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axil_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .rsp_timeout(rsp_timeout), .m_axil(bus)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mon_err = 0;
  int b_cnt = 0;

  always @(posedge ACLK) cyc <= cyc + 1;

  // ---------------- slave model ----------------
  bit          rdy_rand = 1'b0;
  bit          aw_block = 1'b0;
  bit          ar_block = 1'b0;
  bit          mem_load = 1'b1;
  logic [1:0]  slv_resp = 2'b00;
  logic [31:0] mem [16];
  logic        aw_rnd, w_rnd, ar_rnd;
  logic        aw_got, w_got, ar_got, b_valid, r_valid;
  logic [31:0] aw_a, ar_a, wd, r_data;
  logic [3:0]  ws;
  logic [1:0]  b_resp, r_resp;

  assign bus.AW_READY = aw_rnd & ~aw_block;
  assign bus.W_READY  = w_rnd;
  assign bus.AR_READY = ar_rnd & ~ar_block;
  assign bus.B_VALID  = b_valid;
  assign bus.B_RESP   = b_resp;
  assign bus.R_VALID  = r_valid;
  assign bus.R_DATA   = r_data;
  assign bus.R_RESP   = r_resp;

  always @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0; b_valid <= 1'b0; r_valid <= 1'b0;
      aw_rnd <= 1'b1; w_rnd <= 1'b1; ar_rnd <= 1'b1;
      aw_a <= '0; ar_a <= '0; wd <= '0; ws <= '0; r_data <= '0; b_resp <= '0; r_resp <= '0;
      if (mem_load)
        for (int i = 0; i < 16; i++) mem[i] <= {16'(16'h1000 + i), 16'(16'h2000 + i)};
    end else begin
      logic        awh, wh, arh, go;
      logic [31:0] wa, wdat, ra;
      logic [3:0]  wstb;
      awh = bus.AW_VALID && bus.AW_READY;
      wh  = bus.W_VALID && bus.W_READY;
      arh = bus.AR_VALID && bus.AR_READY;
      go  = !rdy_rand || ($urandom_range(0, 3) != 0);
      aw_rnd <= !rdy_rand || ($urandom_range(0, 3) != 0);
      w_rnd  <= !rdy_rand || ($urandom_range(0, 3) != 0);
      ar_rnd <= !rdy_rand || ($urandom_range(0, 3) != 0);
      if (awh) begin aw_got <= 1'b1; aw_a <= bus.AW_ADDR; end
      if (wh)  begin w_got <= 1'b1; wd <= bus.W_DATA; ws <= bus.W_STRB; end
      if (arh) begin ar_got <= 1'b1; ar_a <= bus.AR_ADDR; end
      if (b_valid) begin
        if (bus.B_READY) begin b_valid <= 1'b0; b_cnt <= b_cnt + 1; end
      end else if ((aw_got || awh) && (w_got || wh) && go) begin
        wa   = awh ? bus.AW_ADDR : aw_a;
        wdat = wh ? bus.W_DATA : wd;
        wstb = wh ? bus.W_STRB : ws;
        for (int b = 0; b < 4; b++)
          if (wstb[b]) mem[wa[5:2]][8*b +: 8] <= wdat[8*b +: 8];
        b_valid <= 1'b1; b_resp <= slv_resp; aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (r_valid) begin
        if (bus.R_READY) r_valid <= 1'b0;
      end else if ((ar_got || arh) && go) begin
        ra = arh ? bus.AR_ADDR : ar_a;
        r_data <= mem[ra[5:2]]; r_resp <= slv_resp; r_valid <= 1'b1; ar_got <= 1'b0;
      end
    end
  end

  // ---------------- protocol monitor (stable payload while stalled, VALID drops after handshake) ----------------
  logic        p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
  logic [31:0] p_awa = 0, p_ara = 0, p_wd = 0;
  logic [3:0]  p_ws = 0;

  always @(negedge ACLK) begin
    if (!ARESETn) begin
      p_awv = 0; p_wv = 0; p_arv = 0;
    end else begin
      if (p_awv && !p_awr && (!bus.AW_VALID || bus.AW_ADDR !== p_awa)) mon_err++;
      if (p_awv && p_awr && bus.AW_VALID) mon_err++;
      if (p_wv && !p_wr && (!bus.W_VALID || bus.W_DATA !== p_wd || bus.W_STRB !== p_ws)) mon_err++;
      if (p_wv && p_wr && bus.W_VALID) mon_err++;
      if (p_arv && !p_arr && (!bus.AR_VALID || bus.AR_ADDR !== p_ara)) mon_err++;
      if (p_arv && p_arr && bus.AR_VALID) mon_err++;
      p_awv = bus.AW_VALID; p_awr = bus.AW_READY; p_awa = bus.AW_ADDR;
      p_wv  = bus.W_VALID;  p_wr  = bus.W_READY;  p_wd  = bus.W_DATA; p_ws = bus.W_STRB;
      p_arv = bus.AR_VALID; p_arr = bus.AR_READY; p_ara = bus.AR_ADDR;
    end
  end

  // ---------------- reference model and helpers ----------------
  logic [31:0] ref_mem [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called and returns on a falling edge; n = index of the accepting rising edge.
  task automatic send_cmd(input bit we, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output int n);
    bit ok;
    ok = 0; n = -1;
    cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (cmd_ready) begin ok = 1; n = cyc + 1; end
      @(negedge ACLK);
    end
    cmd_valid = 1'b0;
    chk("cmd_accept", ok, 1);
    if (ok && we)
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_mem[a[5:2]][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic wait_rsp(input string nm, input int n, input int exp_lat, input int hold,
                          input logic [31:0] erd, input logic [1:0] ers, input logic eto);
    bit seen;
    int e;
    seen = 0; e = -1;
    rsp_ready = (hold == 0);
    for (int i = 0; i < 300 && !seen; i++) begin
      if (rsp_valid) begin seen = 1; e = cyc + 1; end
      else @(negedge ACLK);
    end
    chk({nm, "_rsp_seen"}, seen, 1);
    if (seen) begin
      chk({nm, "_rdata"}, rsp_rdata, erd);
      chk({nm, "_resp"}, rsp_resp, ers);
      chk({nm, "_timeout"}, rsp_timeout, eto);
      if (exp_lat >= 0) chk({nm, "_latency"}, e - n, exp_lat);
      for (int k = 0; k < hold; k++) begin
        @(negedge ACLK);
        chk({nm, "_hold_valid"}, rsp_valid, 1);
        chk({nm, "_hold_rdata"}, rsp_rdata, erd);
        chk({nm, "_hold_cmd_ready"}, cmd_ready, 0);
      end
      rsp_ready = 1'b1;
      @(negedge ACLK);
    end
    rsp_ready = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  vec_t vecs [8];

  initial begin
    int n, b0;
    bit we;
    logic [31:0] a, d, erd;
    logic [3:0]  s;
    logic [1:0]  rs;
    int hold;

    vecs[0] = '{1'b1, 32'h08, 32'hdeadbeef, 4'hc, 2'd0, 32'h0,        2'd0};
    vecs[1] = '{1'b0, 32'h08, 32'h0,        4'h0, 2'd0, 32'hdead2002, 2'd0};
    vecs[2] = '{1'b1, 32'h04, 32'h000000ab, 4'h1, 2'd2, 32'h0,        2'd2};
    vecs[3] = '{1'b0, 32'h04, 32'h0,        4'h0, 2'd3, 32'h100120ab, 2'd3};
    vecs[4] = '{1'b1, 32'h3c, 32'h12345678, 4'hf, 2'd0, 32'h0,        2'd0};
    vecs[5] = '{1'b0, 32'h3c, 32'h0,        4'h0, 2'd1, 32'h12345678, 2'd1};
    vecs[6] = '{1'b1, 32'h10, 32'hffffffff, 4'h0, 2'd0, 32'h0,        2'd0};
    vecs[7] = '{1'b0, 32'h10, 32'h0,        4'h0, 2'd0, 32'h10042004, 2'd0};
    for (int i = 0; i < 16; i++) ref_mem[i] = {16'(16'h1000 + i), 16'(16'h2000 + i)};

    // Reset state
    repeat (3) @(negedge ACLK);
    chk("rst_aw_valid", bus.AW_VALID, 0);
    chk("rst_w_valid", bus.W_VALID, 0);
    chk("rst_ar_valid", bus.AR_VALID, 0);
    chk("rst_b_ready", bus.B_READY, 0);
    chk("rst_r_ready", bus.R_READY, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_resp", rsp_resp, 0);
    ARESETn = 1'b1;
    @(negedge ACLK);
    mem_load = 1'b0;
    chk("rst_cmd_ready", cmd_ready, 1);

    // Directed table, slave always ready: minimum latency
    for (int i = 0; i < 8; i++) begin
      slv_resp = vecs[i].sresp;
      send_cmd(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].strb, n);
      wait_rsp($sformatf("vec%0d", i), n, 3, 0, vecs[i].exp_rdata, vecs[i].exp_resp, 1'b0);
    end

    // W handshakes three cycles ahead of AW
    slv_resp = 2'd0;
    aw_block = 1'b1;
    b0 = b_cnt;
    send_cmd(1'b1, 32'h20, 32'hcafef00d, 4'hf, n);
    for (int k = 0; k < 3; k++) begin
      @(negedge ACLK);
      chk("split_w_valid_low", bus.W_VALID, 0);
      chk("split_aw_valid_held", bus.AW_VALID, 1);
      chk("split_aw_addr", bus.AW_ADDR, 32'h20);
    end
    aw_block = 1'b0;
    wait_rsp("split", n, -1, 0, 32'h0, 2'd0, 1'b0);
    chk("split_b_count", b_cnt - b0, 1);

    // Response back-pressure for 5 cycles
    send_cmd(1'b0, 32'h20, 32'h0, 4'h0, n);
    wait_rsp("bp", n, 3, 5, 32'hcafef00d, 2'd0, 1'b0);
    chk("bp_rsp_valid_dropped", rsp_valid, 0);
    chk("bp_cmd_ready_back", cmd_ready, 1);
    send_cmd(1'b0, 32'h3c, 32'h0, 4'h0, n);
    wait_rsp("bp_next", n, 3, 0, 32'h12345678, 2'd0, 1'b0);

    // Reset while AR_VALID is up
    ar_block = 1'b1;
    send_cmd(1'b0, 32'h08, 32'h0, 4'h0, n);
    chk("mid_rst_ar_valid_up", bus.AR_VALID, 1);
    ARESETn = 1'b0;
    #1;
    chk("mid_rst_ar_valid_drop", bus.AR_VALID, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    ar_block = 1'b0;
    @(negedge ACLK);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    send_cmd(1'b0, 32'h08, 32'h0, 4'h0, n);
    wait_rsp("post_rst_read", n, 3, 0, 32'hdead2002, 2'd0, 1'b0);

`ifdef AXIL_MST_TIMEOUT_EN
    // Watchdog: AR_READY never comes
    ar_block = 1'b1;
    send_cmd(1'b0, 32'h08, 32'h0, 4'h0, n);
    wait_rsp("timeout", n, TO_CYC + 1, 0, 32'h0, 2'b11, 1'b1);
    chk("timeout_ar_valid", bus.AR_VALID, 0);
    ar_block = 1'b0;
    send_cmd(1'b0, 32'h3c, 32'h0, 4'h0, n);
    wait_rsp("after_timeout", n, 3, 0, 32'h12345678, 2'd0, 1'b0);
`endif

    // Randomized traffic against the reference memory
    rdy_rand = 1'b1;
    for (int t = 0; t < 150; t++) begin
      we   = 1'($urandom);
      a    = {26'd0, 4'($urandom), 2'b00};
      d    = $urandom;
      s    = 4'($urandom);
      rs   = 2'($urandom);
      hold = $urandom_range(0, 3);
      erd  = we ? 32'h0 : ref_mem[a[5:2]];
      slv_resp = rs;
      send_cmd(we, a, d, s, n);
      wait_rsp($sformatf("rnd%0d", t), n, -1, hold, erd, rs, 1'b0);
    end
    rdy_rand = 1'b0;
    repeat (2) @(negedge ACLK);

    chk("protocol_monitor", mon_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog for the whole run
  initial begin
    #400000;
    errors++;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "run aborted");
  end

endmodule
